pressure_abnormality_monitor: RTL and testbench
===============================================

# pressure_abnormality_monitor

Sequential, parametrised successor to the combinational pressure abnormality path. It takes a stream of parity-protected pressure samples and flags each sample that is out of range and has good parity. It debounces those flags into a hysteretic `alarm`. It also raises `sensor_fault` when parity errors keep repeating. It sits between the pressure sensor interface and the top-level alarm/display logic.

## Interface
Parameters:
- `DATA_W`, 5: pressure field width in bits.
- `LOW_TH`, 4: lowest normal pressure, inclusive, unsigned.
- `HIGH_TH`, 25: highest normal pressure, inclusive, unsigned. `LOW_TH <= HIGH_TH < 2**DATA_W` is required.
- `SET_CNT`, 3: consecutive abnormal samples needed to raise `alarm` (≥1).
- `CLR_CNT`, 3: consecutive normal samples needed to drop `alarm` (≥1).
- `FAULT_CNT`, 4: consecutive parity-error samples needed to raise `sensor_fault` (≥1).

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sample_valid`, input, 1: `sample` is valid this cycle.
- `sample`, input, DATA_W+1: bit [DATA_W] is the parity bit; bits [DATA_W-1:0] are the pressure.
- `abnormal`, output, 1: one-cycle registered pulse for a valid sample with good parity and pressure out of range.
- `parity_err`, output, 1: one-cycle registered pulse for a valid sample with bad parity.
- `alarm`, output, 1: debounced alarm level.
- `sensor_fault`, output, 1: repeated-parity-error level.
- `state`, output, 2: FSM state (debug). 00 NORMAL, 01 PENDING, 10 ALARM, 11 CLEARING.

## Operation
- **Parity:** even parity over all DATA_W+1 bits. If the XOR of `sample` is 1, the sample has a parity error.
- **Range:** a pressure is normal when `LOW_TH <= p <= HIGH_TH`, compared unsigned. Otherwise it is abnormal.
- **Good sample:** valid with good parity. Only good samples advance the FSM.
- **Run counter:** `cnt` is $clog2(max(SET_CNT,CLR_CNT)+1) bits wide.
- **FSM transitions on a good sample:**
  - **NORMAL**
    - Abnormal sample: go to ALARM if SET_CNT==1, else go to PENDING with cnt=1.
    - Normal sample: stay.
  - **PENDING**
    - Abnormal sample: cnt+1. On reaching SET_CNT, go to ALARM and set cnt=0.
    - Normal sample: go to NORMAL and set cnt=0.
  - **ALARM**
    - Normal sample: go to NORMAL if CLR_CNT==1, else go to CLEARING with cnt=1.
    - Abnormal sample: stay.
  - **CLEARING**
    - Normal sample: cnt+1. On reaching CLR_CNT, go to NORMAL and set cnt=0.
    - Abnormal sample: go to ALARM and set cnt=0.
- **`alarm`:** 1 in ALARM or CLEARING. It is decoded from the state register only.
- **Parity-error sample:**
  - FSM state and `cnt` hold.
  - The fault counter increments and saturates at FAULT_CNT.
  - `sensor_fault` = (fault counter == FAULT_CNT).
- **Good sample and fault counter:** any good sample resets the fault counter to 0. `sensor_fault` clears on the same edge.
- **Independence:** `sensor_fault` never changes `alarm`, and `alarm` never changes `sensor_fault`.
- **`sample_valid` low:** all state holds. `abnormal` and `parity_err` are 0. Idle cycles do not break a consecutive run.
- **Pulse exclusivity:** `abnormal` and `parity_err` are never both 1.

## Timing
- **Reset:** `rst` takes priority over `sample_valid`. On reset:
  - `abnormal`=0, `parity_err`=0, `alarm`=0, `sensor_fault`=0.
  - `state`=NORMAL (00); cnt and fault counter are 0.
- **Reset mid-run:** asserting `rst` during a run discards it fully. The first good sample after reset starts from NORMAL.
- **Latency:** a sample presented before edge k produces `abnormal`/`parity_err` after edge k, for exactly one cycle.
- **Alarm latency:** `state` and `alarm` update on the same edge k as the sample that triggers them.
  - `alarm` rises after the edge of the SET_CNT-th consecutive abnormal good sample.
  - It falls after the edge of the CLR_CNT-th consecutive normal good sample.
- **Fault latency:** `sensor_fault` rises after the edge of the FAULT_CNT-th consecutive parity-error sample.
- **Throughput:** back-to-back samples are accepted every cycle. There is no backpressure.

## Test plan
All scenarios use the default parameters.
- **Reset priority:** assert `rst` for 2 cycles with `sample_valid`=1 and `sample`=6'b011110 (p=30).
  - Required: all outputs are 0 and `state`=00 during reset and on the cycle after release.
- **Alarm set:** three valid 6'b011110 samples with an idle cycle between the 2nd and 3rd.
  - Required: `abnormal` pulses 3 times.
  - Required: `state` goes 01, 01, then 10 after the 3rd sample; `alarm`=1 only after the 3rd.
- **Broken run:** 011110, 011110, 001100 (p=12), 011110, 011110.
  - Required: `alarm` stays 0; `state` goes 01, 01, 00, 01, 01.
- **Clear with relapse:** reach ALARM, then send 001100, 001100, 011110, then 001100 ×3.
  - Required: `state` goes 11, 11, 10, 11, 11, 00; `alarm` drops only after the last sample.
- **Sensor fault:** send 6'b111110 ×4 while in PENDING.
  - Required: `parity_err` pulses 4 times; `abnormal`=0; `state` stays 01.
  - Required: `sensor_fault` rises after the 4th; the next sample 6'b001100 clears it and sets `state`=00.
- **Range boundaries:** 6'b100100 (p=4) and 6'b111001 (p=25) give `abnormal`=0. 6'b000011 (p=3) and 6'b111010 (p=26) give `abnormal`=1.

Source files
------------

// File: rtl/pressure_abnormality_monitor.sv
// rtl/pressure_abnormality_monitor.sv - parity-checked pressure range monitor with debounced alarm and sensor fault
module pressure_abnormality_monitor #(
    parameter int DATA_W    = 5,
    parameter int LOW_TH    = 4,
    parameter int HIGH_TH   = 25,
    parameter int SET_CNT   = 3,
    parameter int CLR_CNT   = 3,
    parameter int FAULT_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W:0]   sample,
    output logic              abnormal,
    output logic              parity_err,
    output logic              alarm,
    output logic              sensor_fault,
    output logic [1:0]        state
);

    localparam int MAX_CNT = (SET_CNT > CLR_CNT) ? SET_CNT : CLR_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int FLT_W   = $clog2(FAULT_CNT + 1);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_PENDING  = 2'b01,
        ST_ALARM    = 2'b10,
        ST_CLEARING = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLT_W-1:0]   fault_q, fault_d;

    logic [DATA_W-1:0]  pressure;
    logic               bad_parity;
    logic               out_of_range;
    logic               good;

    assign pressure     = sample[DATA_W-1:0];
    assign bad_parity   = ^sample;
    assign out_of_range = (pressure < DATA_W'(LOW_TH)) || (pressure > DATA_W'(HIGH_TH));
    assign good         = sample_valid && !bad_parity;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (sample_valid && bad_parity) begin
            // Parity errors freeze the debounce FSM and only advance the fault run.
            if (fault_q != FLT_W'(FAULT_CNT))
                fault_d = fault_q + FLT_W'(1);
        end else if (good) begin
            fault_d = '0;
            case (state_q)
                ST_NORMAL: begin
                    if (out_of_range) begin
                        if (SET_CNT == 1) begin
                            state_d = ST_ALARM;
                        end else begin
                            state_d = ST_PENDING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (out_of_range) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(SET_CNT)) begin
                            state_d = ST_ALARM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end
                end
                ST_ALARM: begin
                    if (!out_of_range) begin
                        if (CLR_CNT == 1) begin
                            state_d = ST_NORMAL;
                        end else begin
                            state_d = ST_CLEARING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_CLEARING: begin
                    if (!out_of_range) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(CLR_CNT)) begin
                            state_d = ST_NORMAL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_ALARM;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_NORMAL;
            cnt_q      <= '0;
            fault_q    <= '0;
            abnormal   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            abnormal   <= good && out_of_range;
            parity_err <= sample_valid && bad_parity;
        end
    end

    assign alarm        = (state_q == ST_ALARM) || (state_q == ST_CLEARING);
    assign sensor_fault = (fault_q == FLT_W'(FAULT_CNT));
    assign state        = state_q;

endmodule

// File: tb/tb_pressure_abnormality_monitor.sv
// tb/tb_pressure_abnormality_monitor.sv - scoreboard bench for pressure_abnormality_monitor
module tb_pressure_abnormality_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [5:0] sample = '0;
    logic       abnormal, parity_err, alarm, sensor_fault;
    logic [1:0] state;

    // Expected word: {abnormal, parity_err, alarm, sensor_fault, state[1:0]}
    logic [5:0] want_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         done  = 1'b0;

    localparam logic [5:0] A  = 6'b011110;  // p=30, good parity
    localparam logic [5:0] N  = 6'b001100;  // p=12, good parity
    localparam logic [5:0] PE = 6'b111110;  // parity error

    pressure_abnormality_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .abnormal     (abnormal),
        .parity_err   (parity_err),
        .alarm        (alarm),
        .sensor_fault (sensor_fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic r, input logic v,
                        input logic [5:0] s, input logic [5:0] want);
        @(negedge clk);
        rst          = r;
        sample_valid = v;
        sample       = s;
        want_q.push_back(want);
        name_q.push_back(nm);
    endtask

    always @(posedge clk) begin
        logic [5:0] got;
        logic [5:0] w;
        string      nm;
        #1;
        if (want_q.size() != 0) begin
            w   = want_q.pop_front();
            nm  = name_q.pop_front();
            got = {abnormal, parity_err, alarm, sensor_fault, state};
            n_cmp++;
            if (got !== w) begin
                n_bad++;
                $display("FAIL %s: got {abn,perr,alarm,fault,state}=%b required %b", nm, got, w);
            end
        end
    end

    initial begin
        // reset priority over a valid abnormal sample
        step("rst0", 1, 1, A, 6'b000000);
        step("rst1", 1, 1, A, 6'b000000);
        step("post_rst", 0, 0, A, 6'b000000);
        // alarm set with an idle gap inside the run
        step("set1", 0, 1, A, 6'b100001);
        step("set2", 0, 1, A, 6'b100001);
        step("set_idle", 0, 0, A, 6'b000001);
        step("set3", 0, 1, A, 6'b101010);
        // clear with relapse
        step("clr1", 0, 1, N, 6'b001011);
        step("clr2", 0, 1, N, 6'b001011);
        step("relapse", 0, 1, A, 6'b101010);
        step("clr_a", 0, 1, N, 6'b001011);
        step("clr_b", 0, 1, N, 6'b001011);
        step("clr_c", 0, 1, N, 6'b000000);
        // broken run
        step("brk1", 0, 1, A, 6'b100001);
        step("brk2", 0, 1, A, 6'b100001);
        step("brk3", 0, 1, N, 6'b000000);
        step("brk4", 0, 1, A, 6'b100001);
        step("brk5", 0, 1, A, 6'b100001);
        // parity errors while PENDING
        step("pe1", 0, 1, PE, 6'b010001);
        step("pe2", 0, 1, PE, 6'b010001);
        step("pe3", 0, 1, PE, 6'b010001);
        step("pe4", 0, 1, PE, 6'b010101);
        step("pe_idle", 0, 0, PE, 6'b000101);
        step("pe_clear", 0, 1, N, 6'b000000);
        // range boundaries
        step("p4", 0, 1, 6'b100100, 6'b000000);
        step("p25", 0, 1, 6'b111001, 6'b000000);
        step("p3", 0, 1, 6'b000011, 6'b100001);
        step("p26", 0, 1, 6'b111010, 6'b100001);
        // reset mid-run discards the run
        step("rst_mid", 1, 0, A, 6'b000000);
        step("rerun1", 0, 1, A, 6'b100001);
        step("rerun2", 0, 1, A, 6'b100001);
        step("rerun3", 0, 1, A, 6'b101010);
        // fault in ALARM leaves alarm untouched
        step("af1", 0, 1, PE, 6'b011010);
        step("af2", 0, 1, PE, 6'b011010);
        step("af3", 0, 1, PE, 6'b011010);
        step("af4", 0, 1, PE, 6'b011110);
        step("af_good", 0, 1, A, 6'b101010);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (want_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", want_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
